int_ctrl: RTL and testbench

//  Memory-mapped interrupt controller between the IRQ sources (TC0, TC1, external

---
 rtl/int_ctrl.sv | 112 +++++++++++
 tb/tb_int_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: per-source mask, edge/level mode, pending latch, registered HWInt.
// Optional input synchronizer enabled by defining INT_CTRL_SYNC_EN.
module int_ctrl #(
    parameter int NSRC        = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [31:2]     Addr,
    input  logic [31:0]     Din,
    input  logic            WE,
    output logic [31:0]     Dout,
    output logic [5:0]      HWInt
);

    typedef enum logic [1:0] {
        REG_MASK = 2'd0,
        REG_MODE = 2'd1,
        REG_PEND = 2'd2,
        REG_TOP  = 2'd3
    } regSel_t;

    regSel_t         regSel;
    logic [NSRC-1:0] srcSync;
    logic [NSRC-1:0] prevQ;
    logic [NSRC-1:0] maskQ, maskD;
    logic [NSRC-1:0] modeQ, modeD;
    logic [NSRC-1:0] pendQ, pendD;
    logic [NSRC-1:0] rise, w1c, active;
    logic [5:0]      hwIntQ, hwIntD;
    logic            topValid;
    logic [4:0]      topIdx;
    logic            unusedBits;

    assign regSel     = regSel_t'(Addr[3:2]);
    assign unusedBits = ^{Addr[31:4], Din[31:NSRC]};

`ifdef INT_CTRL_SYNC_EN
    logic [SYNC_STAGES-1:0][NSRC-1:0] syncQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], irq_src};
        end
    end

    assign srcSync = syncQ[SYNC_STAGES-1];
`else
    localparam int unusedSyncStages = SYNC_STAGES;

    assign srcSync = irq_src;
`endif

    // A bit switching level->edge starts cleared; edge->level follows the source right away.
    always_comb begin
        maskD = maskQ;
        modeD = modeQ;
        if (WE && regSel == REG_MASK) maskD = Din[NSRC-1:0];
        if (WE && regSel == REG_MODE) modeD = Din[NSRC-1:0];
        w1c    = (WE && regSel == REG_PEND) ? (Din[NSRC-1:0] & modeQ) : '0;
        rise   = srcSync & ~prevQ;
        pendD  = (~modeD & srcSync) | (modeD & modeQ & (rise | (pendQ & ~w1c)));
        active = pendQ & maskQ;
        hwIntD = '0;
        hwIntD[NSRC-1:0] = active;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevQ  <= '0;
            maskQ  <= '0;
            modeQ  <= '0;
            pendQ  <= '0;
            hwIntQ <= '0;
        end else begin
            prevQ  <= srcSync;
            maskQ  <= maskD;
            modeQ  <= modeD;
            pendQ  <= pendD;
            hwIntQ <= hwIntD;
        end
    end

    assign HWInt = hwIntQ;

    // Scan downward so the lowest active index is the one left standing.
    always_comb begin
        topValid = 1'b0;
        topIdx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                topValid = 1'b1;
                topIdx   = 5'(i);
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (regSel)
            REG_MASK: Dout[NSRC-1:0] = maskQ;
            REG_MODE: Dout[NSRC-1:0] = modeQ;
            REG_PEND: Dout[NSRC-1:0] = pendQ;
            REG_TOP:  Dout = {topValid, 26'b0, topIdx};
            default:  Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; latencies adapt to INT_CTRL_SYNC_EN.
module tb_int_ctrl;

    localparam int NSRC        = 6;
    localparam int SYNC_STAGES = 2;
`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic [31:2]     Addr;
    logic [31:0]     Din;
    logic            WE;
    logic [31:0]     Dout;
    logic [5:0]      HWInt;

    int checkCount = 0;
    int failCount  = 0;

    int_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_src(irq_src),
        .Addr   (Addr),
        .Din    (Din),
        .WE     (WE),
        .Dout   (Dout),
        .HWInt  (HWInt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NSRC-1:0] irq, input int cycles);
        irq_src = irq;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic writeReg(input logic [1:0] sel, input logic [31:0] data);
        Addr = 30'(sel);
        Din  = data;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] sel, input logic [31:0] expected);
        Addr = 30'(sel);
        #1;
        checkOutput(tag, Dout, expected);
    endtask

    initial begin
        reset   = 1'b0;
        irq_src = '0;
        Addr    = '0;
        Din     = '0;
        WE      = 1'b0;
        repeat (2) @(negedge clk);
        checkReg("rst_mask", 2'd0, 32'h0);
        checkReg("rst_mode", 2'd1, 32'h0);
        checkReg("rst_pend", 2'd2, 32'h0);
        checkReg("rst_top",  2'd3, 32'h0);
        checkOutput("rst_hwint", 32'(HWInt), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_hwint", 32'(HWInt), 32'h0);

        // Level mode on source 1
        writeReg(2'd0, 32'h3F);
        checkReg("mask_rb", 2'd0, 32'h3F);
        applyStimulus(6'b000010, LAT + 1);
        checkReg("lvl_pend", 2'd2, 32'h2);
        checkOutput("lvl_hw_early", 32'(HWInt), 32'h0);
        applyStimulus(6'b000010, 1);
        checkOutput("lvl_hw", 32'(HWInt), 32'h2);
        checkReg("lvl_top", 2'd3, 32'h8000_0001);
        applyStimulus(6'b000000, LAT + 1);
        checkReg("lvl_pend_drop", 2'd2, 32'h0);
        checkOutput("lvl_hw_hold", 32'(HWInt), 32'h2);
        applyStimulus(6'b000000, 1);
        checkOutput("lvl_hw_drop", 32'(HWInt), 32'h0);

        // Edge mode: single-cycle pulse on source 2 stays latched
        writeReg(2'd1, 32'h3F);
        applyStimulus(6'b000100, 1);
        applyStimulus(6'b000000, LAT + 3);
        checkReg("edge_pend", 2'd2, 32'h4);
        checkOutput("edge_hw", 32'(HWInt), 32'h4);
        writeReg(2'd2, 32'h4);
        checkReg("w1c_pend", 2'd2, 32'h0);
        checkOutput("w1c_hw_hold", 32'(HWInt), 32'h4);
        @(negedge clk);
        checkOutput("w1c_hw", 32'(HWInt), 32'h0);

        // Edge and W1C in the same cycle: set wins
        applyStimulus(6'b000001, LAT);
        writeReg(2'd2, 32'h1);
        checkReg("set_wins", 2'd2, 32'h1);
        writeReg(2'd2, 32'h1);
        checkReg("w1c_no_edge", 2'd2, 32'h0);
        applyStimulus(6'b000000, LAT + 2);

        // Masking and TOP priority
        writeReg(2'd0, 32'h02);
        applyStimulus(6'b000101, 1);
        applyStimulus(6'b000000, LAT + 3);
        checkReg("mask_pend", 2'd2, 32'h5);
        checkOutput("mask_hw_off", 32'(HWInt), 32'h0);
        checkReg("mask_top_off", 2'd3, 32'h0);
        writeReg(2'd0, 32'h05);
        checkReg("mask_top_on", 2'd3, 32'h8000_0000);
        checkOutput("mask_hw_lag", 32'(HWInt), 32'h0);
        @(negedge clk);
        checkOutput("mask_hw_on", 32'(HWInt), 32'h5);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_hw", 32'(HWInt), 32'h0);
        checkReg("arst_pend", 2'd2, 32'h0);
        checkReg("arst_mode", 2'd1, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Edge->level switch drops a latched bit; TOP writes ignored
        writeReg(2'd0, 32'h3F);
        writeReg(2'd1, 32'h3F);
        applyStimulus(6'b000010, 1);
        applyStimulus(6'b000000, LAT + 3);
        checkReg("e2l_pend_before", 2'd2, 32'h2);
        writeReg(2'd1, 32'h0);
        checkReg("e2l_pend_after", 2'd2, 32'h0);
        writeReg(2'd3, 32'hFFFF_FFFF);
        checkReg("top_ro", 2'd3, 32'h0);
        checkReg("top_ro_mask", 2'd0, 32'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
